fb_write_ctrl: RTL
==================

# fb_write_ctrl

Write-side controller for the 160x120, 1-bit VGA frame buffer. It shares the frame buffer write port between a processor bus requester and an internal fill/clear engine using round-robin arbitration. It also holds the 16-bit foreground/background colour configuration and applies changes only at the start of vertical sync, so colours never change mid-frame. It sits between the bus interface and port A of the dual-port frame buffer, alongside the VGA signal generator that reads port B.

## Interface
- FB_W, 160: frame buffer width in pixels (x range 0..159)
- FB_H, 120: frame buffer height in pixels (y range 0..119)
- RESET_COLOURS, 16'h00FF: reset colour word; [15:8] background = black, [7:0] foreground = white
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- BUS_REQ  in  1  bus write request; held with stable address/data until acknowledged
- BUS_ADDR  in  15  {y[6:0], x[7:0]}
- BUS_DATA  in  1  pixel value to write
- BUS_ACK  out  1  one-cycle grant pulse, combinational in the grant cycle
- FILL_START  in  1  one-cycle pulse; start a full-screen fill
- FILL_VALUE  in  1  pixel value for the fill, sampled at FILL_START
- FILL_BUSY  out  1  high while the fill is in progress
- FILL_DONE  out  1  one-cycle pulse after the last fill write
- COLOUR_WR  in  1  load COLOUR_IN into the shadow register
- COLOUR_IN  in  16  new colour word
- VGA_VS  in  1  vertical sync from the signal generator (active low, synchronous to CLK)
- CONFIG_COLOURS  out  16  active colour word to the signal generator
- FB_WE  out  1  frame buffer write enable, registered
- FB_ADDR  out  15  frame buffer write address, registered
- FB_DATA  out  1  frame buffer write data, registered

## Operation
**Fill FSM**
- States: IDLE, FILL.
- IDLE to FILL on FILL_START: latch FILL_VALUE and set x = y = 0.
- FILL_START during FILL is ignored.
- In FILL, each fill grant writes {y, x}, then advances the counters:
  - if x < 159: x++
  - if x = 159 and y < 119: x = 0, y++
  - if x = 159 and y = 119: FILL_DONE pulses and the FSM returns to IDLE.
- Exactly 19200 writes per fill.

**Arbitration**
- Each cycle, at most one grant.
- Candidates are the bus (BUS_REQ = 1) and the fill engine (state FILL).
- If only one candidate requests, it wins.
- If both request, the winner is the requester not granted last; the last-grant pointer resets to "fill".
- BUS_ACK = 1 in the bus grant cycle. The requester may present the next request in the following cycle.

**Address check**
- A bus address with x > 159 or y > 119 is acknowledged normally.
- Its write is suppressed: FB_WE stays 0 for that grant.

**Colour sequencing**
- COLOUR_WR loads the shadow register.
- On a VGA_VS falling edge (previous sample 1, current 0), CONFIG_COLOURS is loaded from the shadow on the next clock.
- If COLOUR_WR coincides with the edge, COLOUR_IN goes directly to CONFIG_COLOURS and to the shadow.

## Timing
- **Reset values:**
  - FB_WE = 0, FB_ADDR = 0, FB_DATA = 0
  - BUS_ACK = 0, FILL_BUSY = 0, FILL_DONE = 0
  - CONFIG_COLOURS = shadow = RESET_COLOURS
  - FSM = IDLE; VS edge detector sample = 1
- **Write latency:** a grant in cycle N produces FB_WE/FB_ADDR/FB_DATA in cycle N+1, held for one cycle.
- **FILL_BUSY:** registered; high from the cycle after FILL_START through the cycle of the last fill grant.
- **FILL_DONE:** pulses in the cycle after the last fill grant, which is the same cycle as the last FB_WE.
- **Fill duration:** 19200 cycles minimum; 38400 cycles with continuous bus requests (strict alternation).
- **Reset mid-fill:** the fill aborts immediately; FILL_DONE is not generated; no further writes occur.
- **Colour update:** a VS falling edge in cycle N updates CONFIG_COLOURS in cycle N+1.

## Structure
- Package fb_ctrl_pkg holds:
  - FB_W, FB_H
  - FB_ADDR_W = 15
  - RESET_COLOURS
  - the fill state enum {IDLE, FILL}
  - an address-packing function {y[6:0], x[7:0]}
- One sub-module, fb_fill_scan, contains:
  - the x/y raster counters
  - the fill FSM
  - inputs: advance, start; outputs: addr, busy, last
- The arbiter, address check, output register and colour shadow stay in the top level.

## Test plan
- **Reset:** assert RESET mid-run. Expect CONFIG_COLOURS = 16'h00FF, FB_WE = 0, FILL_BUSY = 0.
- **Single bus write:** BUS_REQ with addr {7'd5, 8'd10}, data 1. Expect BUS_ACK in the same cycle, then FB_WE = 1, FB_ADDR = 15'h050A, FB_DATA = 1 one cycle later.
- **Fill alone:** FILL_START, FILL_VALUE = 0. Expect exactly 19200 writes with addresses 0x0000, 0x0001 … 0x009F, 0x0100 … 0x779F, then FILL_DONE after 19200 write cycles.
- **Contention:** bus held requesting during a fill. Expect grants to alternate bus/fill every cycle and FILL_DONE after 38400 cycles.
- **Out-of-range bus write:** BUS_ADDR x = 160. Expect BUS_ACK = 1 and no FB_WE.
- **Colour sequencing:** COLOUR_WR 16'h1CE0 while VGA_VS = 1. Expect CONFIG_COLOURS to stay 16'h00FF until one cycle after VGA_VS falls, then become 16'h1CE0.

Source files
------------

// File: rtl/fb_ctrl_pkg.sv
// Shared constants, fill FSM state type and address helpers for the
// frame buffer write-side controller.
package fb_ctrl_pkg;

  localparam int FB_W = 160;
  localparam int FB_H = 120;
  localparam int FB_ADDR_W = 15;
  localparam logic [15:0] RESET_COLOURS = 16'h00FF;

  localparam logic [7:0] X_MAX = 8'(FB_W - 1);
  localparam logic [6:0] Y_MAX = 7'(FB_H - 1);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  function automatic logic [FB_ADDR_W-1:0] pack_addr(input logic [7:0] x, input logic [6:0] y);
    return {y, x};
  endfunction

  // Bus addresses use the same {y, x} packing; anything off-screen is dropped.
  function automatic logic addr_in_range(input logic [FB_ADDR_W-1:0] addr);
    return (addr[7:0] <= X_MAX) && (addr[14:8] <= Y_MAX);
  endfunction

endpackage

// File: rtl/fb_fill_scan.sv
// Raster scan counters and fill FSM: walks every pixel address once per fill,
// stepping only when the arbiter hands the fill engine a write slot.
module fb_fill_scan
  import fb_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 advance,
  output logic [FB_ADDR_W-1:0] addr,
  output logic                 busy,
  output logic                 last
);

  fill_state_t state, state_next;
  logic [7:0] x;
  logic [6:0] y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = FILL;
      FILL: if (advance && last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == FILL);
    last = busy && (x == X_MAX) && (y == Y_MAX);
    addr = pack_addr(x, y);
  end

  // Counters move only on a granted fill write, so bus contention stretches the fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (state == IDLE && start) begin
      x <= '0;
      y <= '0;
    end else if (state == FILL && advance) begin
      if (x == X_MAX) begin
        x <= '0;
        y <= (y == Y_MAX) ? '0 : y + 7'd1;
      end else begin
        x <= x + 8'd1;
      end
    end
  end

endmodule

// File: rtl/fb_write_ctrl.sv
// Frame buffer port A write controller: round-robin arbitration between the
// processor bus and the fill engine, plus vsync-aligned colour configuration.
module fb_write_ctrl
  import fb_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bus_req,
  input  logic [FB_ADDR_W-1:0] bus_addr,
  input  logic                 bus_data,
  output logic                 bus_ack,
  input  logic                 fill_start,
  input  logic                 fill_value,
  output logic                 fill_busy,
  output logic                 fill_done,
  input  logic                 colour_wr,
  input  logic [15:0]          colour_in,
  input  logic                 vga_vs,
  output logic [15:0]          config_colours,
  output logic                 fb_we,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic                 fb_data
);

  logic [FB_ADDR_W-1:0] scan_addr;
  logic scan_busy, scan_last;
  logic bus_grant, fill_grant, addr_ok;
  logic last_bus;
  logic fill_val_q;
  logic vs_prev;
  logic [15:0] shadow;

  fb_fill_scan u_scan (
    .clk     (clk),
    .rst     (rst),
    .start   (fill_start),
    .advance (fill_grant),
    .addr    (scan_addr),
    .busy    (scan_busy),
    .last    (scan_last)
  );

  // Under contention the requester that did not win last time gets the slot.
  always_comb begin
    bus_grant  = bus_req && (!scan_busy || !last_bus);
    fill_grant = scan_busy && !bus_grant;
    addr_ok    = addr_in_range(bus_addr);
  end

  assign bus_ack   = bus_grant;
  assign fill_busy = scan_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_bus   <= 1'b0;
      fill_val_q <= 1'b0;
      fill_done  <= 1'b0;
    end else begin
      if (bus_grant) begin
        last_bus <= 1'b1;
      end else if (fill_grant) begin
        last_bus <= 1'b0;
      end
      if (fill_start && !scan_busy) begin
        fill_val_q <= fill_value;
      end
      fill_done <= fill_grant && scan_last;
    end
  end

  // Out-of-range bus grants still consume the slot but never raise the write enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_we   <= 1'b0;
      fb_addr <= '0;
      fb_data <= 1'b0;
    end else begin
      fb_we <= bus_grant ? addr_ok : fill_grant;
      if (bus_grant && addr_ok) begin
        fb_addr <= bus_addr;
        fb_data <= bus_data;
      end else if (fill_grant) begin
        fb_addr <= scan_addr;
        fb_data <= fill_val_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_prev        <= 1'b1;
      shadow         <= RESET_COLOURS;
      config_colours <= RESET_COLOURS;
    end else begin
      vs_prev <= vga_vs;
      if (colour_wr) begin
        shadow <= colour_in;
      end
      if (vs_prev && !vga_vs) begin
        config_colours <= colour_wr ? colour_in : shadow;
      end
    end
  end

endmodule
